rf_write_arbiter: RTL and testbench

- Owns the single write port (we3/a3/wd3) of the 32x32 MIPS register file in the multi-cycle core.
- After reset it sweeps registers 1..31 to zero. It then shares the port between the core writeback path, which has priority, and a debug/loader requester that uses a valid/ready handshake.
- A starvation counter guarantees the debug requester a grant within a bounded number of cycles.

---
 rtl/rf_write_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Owns the single write port (we3/a3/wd3) of the 32x32 MIPS register file.
// After reset it sweeps registers 1..31 to zero (when INIT_CLEAR = 1). It then
// shares the port between the core writeback path and a debug/loader requester:
//   - The core writeback path has priority.
//   - The debug requester uses a valid/ready handshake.
// A starvation counter bounds how long a pending debug request can be blocked.
// Once that bound is hit, the core is stalled for one cycle (GRANT) so that the
// debug write can land.
//
// Parameters
//   STARVE_LIMIT  consecutive blocked cycles before the core is stalled (1..15)
//   INIT_CLEAR    1 = zero sweep after reset, 0 = go straight to RUN
//
// Optional feature (macro RF_WRARB_STATS_EN)
//   When defined, adds two saturating 16-bit statistics outputs:
//   dbg_grant_cnt_o and starve_evt_cnt_o.
//
// Ports
//   clk, rst_n_i                       clock, asynchronous active-low reset
//   core_we_i, core_a3_i, core_wd3_i   core writeback request
//   dbg_valid_i, dbg_a3_i, dbg_wd3_i   debug write request
//   dbg_ready_o                        debug write accepted this cycle
//   stall_o                            registered core stall
//   init_busy_o                        zero sweep in progress
//   rf_we3_o, rf_a3_o, rf_wd3_o        register file write port
//   dbg_grant_cnt_o                    completed debug handshakes (stats only)
//   starve_evt_cnt_o                   entries into GRANT (stats only)
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int INIT_CLEAR   = 1
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        core_we_i,
  input  logic [4:0]  core_a3_i,
  input  logic [31:0] core_wd3_i,
  input  logic        dbg_valid_i,
  output logic        dbg_ready_o,
  input  logic [4:0]  dbg_a3_i,
  input  logic [31:0] dbg_wd3_i,
  output logic        stall_o,
  output logic        init_busy_o,
  output logic        rf_we3_o,
  output logic [4:0]  rf_a3_o,
  output logic [31:0] rf_wd3_o
`ifdef RF_WRARB_STATS_EN
  ,
  output logic [15:0] dbg_grant_cnt_o,
  output logic [15:0] starve_evt_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam state_t     RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
  localparam logic       RESET_BUSY  = (INIT_CLEAR != 0);
  // The transition to GRANT is taken on the edge that would bring the
  // counter up to STARVE_LIMIT. Comparing against LIMIT-1 therefore makes
  // stall_o rise right after the STARVE_LIMIT-th blocked cycle.
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);
  localparam logic [4:0] SWEEP_FIRST = 5'd1;
  localparam logic [4:0] SWEEP_LAST  = 5'd31;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_reg;
  logic [4:0]  sweep_cnt_reg;
  logic [3:0]  starve_cnt_reg;
  logic        stall_reg;
  logic        init_busy_reg;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic core_sel;     // port carries the core write this cycle
  logic dbg_sel;      // port carries the debug write (handshake completes)
  logic dbg_blocked;  // debug pending but the core owns the port (RUN only)
  logic starve_hit;   // this blocked cycle exhausts the starvation budget
  logic sweep_last;   // final register of the zero sweep

  always_comb begin
    core_sel = 1'b0;
    dbg_sel  = 1'b0;
    case (state_reg)
      // In GRANT the core is already stalled. If it still drives a write, that
      // is a protocol violation, and the core keeps priority so that its
      // write is not lost.
      ST_RUN, ST_GRANT: begin
        core_sel = core_we_i;
        dbg_sel  = dbg_valid_i && !core_we_i;
      end
      default: begin
        core_sel = 1'b0;
        dbg_sel  = 1'b0;
      end
    endcase
    // Keep the port and the handshake quiet while reset is held. With
    // INIT_CLEAR = 0 the reset state is RUN, which would otherwise pass
    // requests straight through.
    if (!rst_n_i) begin
      core_sel = 1'b0;
      dbg_sel  = 1'b0;
    end
  end

  assign dbg_blocked = (state_reg == ST_RUN) && dbg_valid_i && core_we_i;
  assign starve_hit  = dbg_blocked && (starve_cnt_reg == STARVE_LAST);
  assign sweep_last  = (sweep_cnt_reg == SWEEP_LAST);

  // ---------------------------------------------------------------------------
  // Register-file port mux (combinational, zero added latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we3_o = 1'b0;
    rf_a3_o  = dbg_a3_i;
    rf_wd3_o = dbg_wd3_i;
    if (state_reg == ST_INIT) begin
      rf_we3_o = rst_n_i;
      rf_a3_o  = sweep_cnt_reg;
      rf_wd3_o = 32'd0;
    end else if (core_sel) begin
      rf_we3_o = 1'b1;
      rf_a3_o  = core_a3_i;
      rf_wd3_o = core_wd3_i;
    end else begin
      // Debug write when dbg_sel is set. Otherwise this is idle, and a3/wd3
      // stay on the debug inputs so that the RF port does not toggle.
      rf_we3_o = dbg_sel;
    end
  end

  assign dbg_ready_o = dbg_sel;
  assign stall_o     = stall_reg;
  assign init_busy_o = init_busy_reg;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= RESET_STATE;
      sweep_cnt_reg  <= SWEEP_FIRST;
      starve_cnt_reg <= 4'd0;
      stall_reg      <= RESET_BUSY;
      init_busy_reg  <= RESET_BUSY;
    end else begin
      case (state_reg)
        ST_INIT: begin
          // The sweep counter stays at 31 once done; only a reset restarts it.
          if (sweep_last) begin
            state_reg     <= ST_RUN;
            stall_reg     <= 1'b0;
            init_busy_reg <= 1'b0;
          end else begin
            sweep_cnt_reg <= sweep_cnt_reg + 5'd1;
          end
        end

        ST_RUN: begin
          if (starve_hit) begin
            state_reg      <= ST_GRANT;
            stall_reg      <= 1'b1;
            starve_cnt_reg <= 4'd0;
          end else if (dbg_blocked) begin
            starve_cnt_reg <= starve_cnt_reg + 4'd1;
          end else begin
            // Clear on a debug grant, and also when no debug request is
            // pending. A dropped request leaves no history behind.
            starve_cnt_reg <= 4'd0;
          end
        end

        ST_GRANT: begin
          state_reg      <= ST_RUN;
          stall_reg      <= 1'b0;
          starve_cnt_reg <= 4'd0;
        end

        default: begin
          // Unreachable encoding: recover the same way a reset would.
          state_reg      <= RESET_STATE;
          sweep_cnt_reg  <= SWEEP_FIRST;
          starve_cnt_reg <= 4'd0;
          stall_reg      <= RESET_BUSY;
          init_busy_reg  <= RESET_BUSY;
        end
      endcase
    end
  end

`ifdef RF_WRARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [15:0] dbg_grant_cnt_reg;
  logic [15:0] starve_evt_cnt_reg;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dbg_grant_cnt_reg  <= 16'd0;
      starve_evt_cnt_reg <= 16'd0;
    end else begin
      if (dbg_sel && (dbg_grant_cnt_reg != 16'hFFFF))
        dbg_grant_cnt_reg <= dbg_grant_cnt_reg + 16'd1;
      if (starve_hit && (starve_evt_cnt_reg != 16'hFFFF))
        starve_evt_cnt_reg <= starve_evt_cnt_reg + 16'd1;
    end
  end

  assign dbg_grant_cnt_o  = dbg_grant_cnt_reg;
  assign starve_evt_cnt_o = starve_evt_cnt_reg;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed testbench for rf_write_arbiter (STARVE_LIMIT = 4, INIT_CLEAR = 1).
// A small register-file model captures every write the arbiter issues, so that
// the final register contents can be checked.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_we;
  logic [4:0]  core_a3;
  logic [31:0] core_wd3;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_a3;
  logic [31:0] dbg_wd3;
  logic        stall;
  logic        init_busy;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
`ifdef RF_WRARB_STATS_EN
  logic [15:0] dbg_grant_cnt;
  logic [15:0] starve_evt_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  logic [31:0] rf_model [32];

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .STARVE_LIMIT(4),
    .INIT_CLEAR  (1)
  ) dut (
    .clk        (clk),
    .rst_n_i    (rst_n),
    .core_we_i  (core_we),
    .core_a3_i  (core_a3),
    .core_wd3_i (core_wd3),
    .dbg_valid_i(dbg_valid),
    .dbg_ready_o(dbg_ready),
    .dbg_a3_i   (dbg_a3),
    .dbg_wd3_i  (dbg_wd3),
    .stall_o    (stall),
    .init_busy_o(init_busy),
    .rf_we3_o   (rf_we3),
    .rf_a3_o    (rf_a3),
    .rf_wd3_o   (rf_wd3)
`ifdef RF_WRARB_STATS_EN
    ,
    .dbg_grant_cnt_o (dbg_grant_cnt),
    .starve_evt_cnt_o(starve_evt_cnt)
`endif
  );

  // Register file model: register 0 discards writes. While reset is held,
  // it is filled with nonzero garbage so that the zero sweep is observable.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_model[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (rf_we3 && rf_a3 != 5'd0) begin
      rf_model[rf_a3] <= rf_wd3;
    end
  end

  // Stimulus helper: drive one cycle of inputs, then wait for the sample point.
  task automatic drive(input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    core_we = cw; core_a3 = ca; core_wd3 = cd;
    dbg_valid = dv; dbg_a3 = da; dbg_wd3 = dd;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    core_we = 1'b1; core_a3 = 5'd9; core_wd3 = 32'h1;
    dbg_valid = 1'b1; dbg_a3 = 5'd2; dbg_wd3 = 32'h2;
    repeat (3) @(negedge clk);
    checks++;
    if (rf_we3 !== 1'b0 || dbg_ready !== 1'b0 || stall !== 1'b1 || init_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: we=%b ready=%b stall=%b busy=%b, expected we=0 ready=0 stall=1 busy=1",
               rf_we3, dbg_ready, stall, init_busy);
    end
    $display("reset_state: we=%b ready=%b stall=%b busy=%b", rf_we3, dbg_ready, stall, init_busy);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Entered just after reset release. Requests stay asserted during the sweep
  // to show that they are ignored there.
  task automatic test_init_sweep;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we3 !== 1'b1 || rf_a3 !== 5'(k) || rf_wd3 !== 32'd0 || init_busy !== 1'b1 ||
          stall !== 1'b1 || dbg_ready !== 1'b0) begin
        fails++;
        $display("FAIL sweep_%0d: we=%b a3=%0d wd=%h busy=%b stall=%b ready=%b, expected we=1 a3=%0d wd=0 busy=1 stall=1 ready=0",
                 k, rf_we3, rf_a3, rf_wd3, init_busy, stall, dbg_ready, k);
      end
      if (k == 31) begin
        @(posedge clk);
        #1;
        core_we = 1'b0; dbg_valid = 1'b0; dbg_a3 = 5'd0; dbg_wd3 = 32'd0;
      end
    end
    $display("init_sweep: 31 sweep cycles sampled");
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b0 || stall !== 1'b0 || rf_we3 !== 1'b0) begin
      fails++;
      $display("FAIL sweep_end: busy=%b stall=%b we=%b, expected busy=0 stall=0 we=0",
               init_busy, stall, rf_we3);
    end
    for (int i = 1; i < 32; i++) begin
      checks++;
      if (rf_model[i] !== 32'd0) begin
        fails++;
        $display("FAIL sweep_reg%0d: got %h, expected 00000000", i, rf_model[i]);
      end
    end
    $display("sweep_end: busy=%b stall=%b, regs 1..31 checked", init_busy, stall);
  endtask

  task automatic test_core_priority;
    drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b1, 5'd9, 32'h1111_1111);
    checks++;
    if (rf_we3 !== 1'b1 || rf_a3 !== 5'd8 || rf_wd3 !== 32'hDEADBEEF || dbg_ready !== 1'b0) begin
      fails++;
      $display("FAIL core_priority: we=%b a3=%0d wd=%h ready=%b, expected we=1 a3=8 wd=deadbeef ready=0",
               rf_we3, rf_a3, rf_wd3, dbg_ready);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (rf_model[8] !== 32'hDEADBEEF || rf_model[9] !== 32'd0) begin
      fails++;
      $display("FAIL core_priority_rf: reg8=%h reg9=%h, expected reg8=deadbeef reg9=00000000",
               rf_model[8], rf_model[9]);
    end
    $display("core_priority: reg8=%h reg9=%h", rf_model[8], rf_model[9]);
  endtask

  task automatic test_dbg_write;
    drive(1'b0, 5'd3, 32'h0, 1'b1, 5'd5, 32'h12345678);
    checks++;
    if (dbg_ready !== 1'b1 || rf_we3 !== 1'b1 || rf_a3 !== 5'd5 || rf_wd3 !== 32'h12345678) begin
      fails++;
      $display("FAIL dbg_write: ready=%b we=%b a3=%0d wd=%h, expected ready=1 we=1 a3=5 wd=12345678",
               dbg_ready, rf_we3, rf_a3, rf_wd3);
    end
    // Idle: the port is quiet, and a3/wd3 follow the debug inputs.
    drive(1'b0, 5'd3, 32'h0, 1'b0, 5'd7, 32'h0BAD_F00D);
    checks++;
    if (rf_we3 !== 1'b0 || dbg_ready !== 1'b0 || rf_a3 !== 5'd7 || rf_wd3 !== 32'h0BAD_F00D ||
        rf_model[5] !== 32'h12345678 || rf_model[7] !== 32'd0) begin
      fails++;
      $display("FAIL dbg_idle: we=%b ready=%b a3=%0d wd=%h reg5=%h reg7=%h, expected we=0 ready=0 a3=7 wd=0badf00d reg5=12345678 reg7=0",
               rf_we3, dbg_ready, rf_a3, rf_wd3, rf_model[5], rf_model[7]);
    end
    $display("dbg_write: reg5=%h", rf_model[5]);
  endtask

  task automatic test_starvation;
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 5'(10 + c), 32'hC000_0000 | 32'(c), 1'b1, 5'd20, 32'hCAFEF00D);
      checks++;
      if (stall !== 1'b0 || dbg_ready !== 1'b0 || rf_a3 !== 5'(10 + c)) begin
        fails++;
        $display("FAIL starve_blocked_%0d: stall=%b ready=%b a3=%0d, expected stall=0 ready=0 a3=%0d",
                 c, stall, dbg_ready, rf_a3, 10 + c);
      end
    end
    // GRANT: the core obeys the stall, and debug is granted.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hCAFEF00D);
    checks++;
    if (stall !== 1'b1 || dbg_ready !== 1'b1 || rf_we3 !== 1'b1 || rf_a3 !== 5'd20 ||
        rf_wd3 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL starve_grant: stall=%b ready=%b we=%b a3=%0d wd=%h, expected stall=1 ready=1 we=1 a3=20 wd=cafef00d",
               stall, dbg_ready, rf_we3, rf_a3, rf_wd3);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall !== 1'b0 || rf_model[20] !== 32'hCAFEF00D || rf_model[14] !== 32'hC000_0004) begin
      fails++;
      $display("FAIL starve_after: stall=%b reg20=%h reg14=%h, expected stall=0 reg20=cafef00d reg14=c0000004",
               stall, rf_model[20], rf_model[14]);
    end
    $display("starvation: stall=%b reg20=%h", stall, rf_model[20]);
  endtask

  task automatic test_grant_core_violation;
    for (int c = 1; c <= 4; c++) drive(1'b1, 5'd16, 32'h0000_1600, 1'b1, 5'd22, 32'h2222_2222);
    // The core keeps writing in GRANT, so it wins and debug is refused.
    drive(1'b1, 5'd14, 32'h1414_1414, 1'b1, 5'd22, 32'h2222_2222);
    checks++;
    if (stall !== 1'b1 || dbg_ready !== 1'b0 || rf_a3 !== 5'd14 || rf_wd3 !== 32'h1414_1414) begin
      fails++;
      $display("FAIL grant_violation: stall=%b ready=%b a3=%0d wd=%h, expected stall=1 ready=0 a3=14 wd=14141414",
               stall, dbg_ready, rf_a3, rf_wd3);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall !== 1'b0 || rf_model[14] !== 32'h1414_1414 || rf_model[22] !== 32'd0) begin
      fails++;
      $display("FAIL grant_violation_after: stall=%b reg14=%h reg22=%h, expected stall=0 reg14=14141414 reg22=0",
               stall, rf_model[14], rf_model[22]);
    end
    $display("grant_violation: reg14=%h reg22=%h", rf_model[14], rf_model[22]);
  endtask

  task automatic test_addr0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hAAAA_AAAA);
    checks++;
    if (rf_we3 !== 1'b1 || rf_a3 !== 5'd0 || dbg_ready !== 1'b1 || rf_wd3 !== 32'hAAAA_AAAA) begin
      fails++;
      $display("FAIL addr0_dbg: we=%b a3=%0d ready=%b wd=%h, expected we=1 a3=0 ready=1 wd=aaaaaaaa",
               rf_we3, rf_a3, dbg_ready, rf_wd3);
    end
    drive(1'b1, 5'd0, 32'h5555_5555, 1'b0, 5'd0, 32'd0);
    checks++;
    if (rf_we3 !== 1'b1 || rf_a3 !== 5'd0 || rf_wd3 !== 32'h5555_5555) begin
      fails++;
      $display("FAIL addr0_core: we=%b a3=%0d wd=%h, expected we=1 a3=0 wd=55555555",
               rf_we3, rf_a3, rf_wd3);
    end
    $display("addr0: forwarded with we=%b", rf_we3);
  endtask

  // A dbg_valid gap clears the starvation count: 2 + 3 blocked cycles never stall.
  task automatic test_dbg_drop;
    drive(1'b1, 5'd17, 32'h17, 1'b1, 5'd12, 32'h1212_1212);
    drive(1'b1, 5'd17, 32'h17, 1'b1, 5'd12, 32'h1212_1212);
    drive(1'b1, 5'd17, 32'h17, 1'b0, 5'd12, 32'h1212_1212);
    for (int c = 1; c <= 3; c++) drive(1'b1, 5'd17, 32'h17, 1'b1, 5'd12, 32'h1212_1212);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212_1212);
    checks++;
    if (stall !== 1'b0 || dbg_ready !== 1'b1 || rf_a3 !== 5'd12) begin
      fails++;
      $display("FAIL dbg_drop: stall=%b ready=%b a3=%0d, expected stall=0 ready=1 a3=12",
               stall, dbg_ready, rf_a3);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall !== 1'b0 || rf_model[12] !== 32'h1212_1212) begin
      fails++;
      $display("FAIL dbg_drop_after: stall=%b reg12=%h, expected stall=0 reg12=12121212",
               stall, rf_model[12]);
    end
    $display("dbg_drop: reg12=%h", rf_model[12]);
  endtask

  task automatic test_reset_mid_sweep;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) @(negedge clk);
    checks++;
    if (rf_a3 !== 5'd17 || init_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_sweep_addr: a3=%0d busy=%b, expected a3=17 busy=1", rf_a3, init_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_we3 !== 1'b0 || init_busy !== 1'b1 || stall !== 1'b1 || rf_a3 !== 5'd1) begin
      fails++;
      $display("FAIL mid_sweep_reset: we=%b busy=%b stall=%b a3=%0d, expected we=0 busy=1 stall=1 a3=1",
               rf_we3, init_busy, stall, rf_a3);
    end
`ifdef RF_WRARB_STATS_EN
    checks++;
    if (dbg_grant_cnt !== 16'd0 || starve_evt_cnt !== 16'd0) begin
      fails++;
      $display("FAIL stats_reset: grants=%0d starves=%0d, expected 0 and 0",
               dbg_grant_cnt, starve_evt_cnt);
    end
`endif
    $display("mid_sweep_reset: we=%b a3=%0d", rf_we3, rf_a3);
    @(posedge clk);
    #1;
    core_we = 1'b1; dbg_valid = 1'b1;
    rst_n = 1'b1;
    test_init_sweep();
  endtask

  // After the fresh reset: 2 plain debug writes plus 1 starvation grant.
  task automatic test_stats;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0003);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0004);
    for (int c = 1; c <= 4; c++) drive(1'b1, 5'd15, 32'h0000_0015, 1'b1, 5'd21, 32'h0000_0021);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h0000_0021);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (rf_model[3] !== 32'h3 || rf_model[4] !== 32'h4 || rf_model[21] !== 32'h21 ||
        rf_model[15] !== 32'h15) begin
      fails++;
      $display("FAIL stats_rf: reg3=%h reg4=%h reg21=%h reg15=%h, expected 3 4 21 15",
               rf_model[3], rf_model[4], rf_model[21], rf_model[15]);
    end
`ifdef RF_WRARB_STATS_EN
    checks++;
    if (dbg_grant_cnt !== 16'd3 || starve_evt_cnt !== 16'd1) begin
      fails++;
      $display("FAIL stats_counts: grants=%0d starves=%0d, expected 3 and 1",
               dbg_grant_cnt, starve_evt_cnt);
    end
    $display("stats: grants=%0d starves=%0d", dbg_grant_cnt, starve_evt_cnt);
`endif
    $display("stats_rf: reg3=%h reg4=%h reg21=%h", rf_model[3], rf_model[4], rf_model[21]);
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_core_priority();
    test_dbg_write();
    test_starvation();
    test_grant_core_violation();
    test_addr0();
    test_dbg_drop();
    test_reset_mid_sweep();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
